md_sequencer: RTL and testbench

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer_pkg.sv | 27 ++
 rtl/md_arith.sv | 58 +++++
 rtl/md_sequencer.sv | 103 ++++++++++
 tb/tb_md_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// rtl/md_sequencer_pkg.sv - shared op codes, latency defaults and FSM encodings for the MD unit
package md_sequencer_pkg;

    localparam logic [3:0] OP_MD_NONE = 4'd0;
    localparam logic [3:0] OP_MULT    = 4'd1;
    localparam logic [3:0] OP_MULTU   = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;
    localparam logic [3:0] OP_DIVU    = 4'd4;
    localparam logic [3:0] OP_MTHI    = 4'd5;
    localparam logic [3:0] OP_MTLO    = 4'd6;
    localparam logic [3:0] OP_MFHI    = 4'd7;
    localparam logic [3:0] OP_MFLO    = 4'd8;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W       = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    function automatic logic is_md_calc(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 64-bit product / quotient-remainder for the MD unit
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        mag_q;
    logic [31:0]        mag_r;
    logic [31:0]        sq;
    logic [31:0]        sr;
    logic [31:0]        uq;
    logic [31:0]        ur;

    assign sa     = {{32{a[31]}}, a};
    assign sb     = {{32{b[31]}}, b};
    assign prod_s = sa * sb;
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes: 0x80000000 / -1 naturally wraps back to 0x80000000.
    assign abs_a = a[31] ? (32'd0 - a) : a;
    assign abs_b = b[31] ? (32'd0 - b) : b;
    assign mag_q = (b == 32'd0) ? 32'd0 : abs_a / abs_b;
    assign mag_r = (b == 32'd0) ? 32'd0 : abs_a % abs_b;
    assign sq    = (a[31] ^ b[31]) ? (32'd0 - mag_q) : mag_q;
    assign sr    = a[31] ? (32'd0 - mag_r) : mag_r;
    assign uq    = (b == 32'd0) ? 32'd0 : a / b;
    assign ur    = (b == 32'd0) ? 32'd0 : a % b;

    always_comb begin
        result   = 64'd0;
        div_zero = 1'b0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                result   = {sr, sq};
                div_zero = (b == 32'd0);
            end
            OP_DIVU: begin
                result   = {ur, uq};
                div_zero = (b == 32'd0);
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle HI/LO sequencer with pipeline stall generation
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_num1,
    input  logic [31:0] e_num2,
    input  logic        d_md_use,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        start,
    output logic        busy,
    output logic        md_stall
);

    md_state_t        state_q;
    md_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lat_sel;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_ok;
    logic [63:0]      arith_res;
    logic             arith_div_zero;

    md_arith u_arith (
        .op       (e_op),
        .a        (e_num1),
        .b        (e_num2),
        .result   (arith_res),
        .div_zero (arith_div_zero)
    );

    assign lat_sel  = ((e_op == OP_DIV) || (e_op == OP_DIVU)) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    assign md_stall = d_md_use & (start | busy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_md_calc(e_op)) begin
                    start   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result is latched at start so the E-stage operands may change during BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_d == ST_BUSY);
            if (state_q == ST_IDLE) begin
                if (start) begin
                    cnt_q   <= lat_sel;
                    pend_hi <= arith_res[63:32];
                    pend_lo <= arith_res[31:0];
                    pend_ok <= ~arith_div_zero;
                end else if (e_op == OP_MTHI) begin
                    hi <= e_num1;
                end else if (e_op == OP_MTLO) begin
                    lo <= e_num1;
                end
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
                // Divide-by-zero still spends the full latency but never commits.
                if (cnt_q == CNT_W'(1) && pend_ok) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - directed self-checking bench for md_sequencer
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  e_op;
    logic [31:0] e_num1;
    logic [31:0] e_num2;
    logic        d_md_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        start;
    logic        busy;
    logic        md_stall;

    int errors = 0;
    int checks = 0;

    md_sequencer #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .e_op     (e_op),
        .e_num1   (e_num1),
        .e_num2   (e_num2),
        .d_md_use (d_md_use),
        .hi       (hi),
        .lo       (lo),
        .start    (start),
        .busy     (busy),
        .md_stall (md_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one calc op, follow the whole busy window, then check the committed HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_d, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int n;
        old_hi   = hi;
        old_lo   = lo;
        e_op     = op;
        e_num1   = a;
        e_num2   = b;
        d_md_use = use_d;
        #1;
        chk({tag, "_start"}, 32'(start), 32'd1);
        chk({tag, "_stall_start"}, 32'(md_stall), 32'(use_d));
        tick();
        e_op   = OP_MD_NONE;
        e_num1 = 32'hA5A5_A5A5;
        e_num2 = 32'h5A5A_5A5A;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            if (hi !== old_hi || lo !== old_lo || md_stall !== use_d || start !== 1'b0)
                chk({tag, "_during_busy"}, {hi ^ old_hi} | {lo ^ old_lo}, 32'd0);
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(lat));
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_stall_after"}, 32'(md_stall), 32'd0);
        d_md_use = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        e_op     = OP_MD_NONE;
        e_num1   = '0;
        e_num2   = '0;
        d_md_use = 1'b0;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // MFHI/MFLO leave state untouched and need no start
        e_op     = OP_MFHI;
        d_md_use = 1'b1;
        #1;
        chk("mfhi_start", 32'(start), 32'd0);
        chk("mfhi_stall", 32'(md_stall), 32'd0);
        tick();
        chk("mfhi_hi", hi, 32'hFFFF_FFFF);
        d_md_use = 1'b0;

        e_op   = OP_MTHI;
        e_num1 = 32'h11;
        tick();
        chk("mthi", hi, 32'h11);
        e_op   = OP_MTLO;
        e_num1 = 32'h22;
        tick();
        chk("mtlo", lo, 32'h22);
        chk("mtlo_hi_kept", hi, 32'h11);

        run_op("divu0", OP_DIVU, 32'h1234, 32'd0, 1'b0, 10, 32'h11, 32'h22);
        run_op("div0", OP_DIV, 32'hFFFF_0000, 32'd0, 1'b1, 10, 32'h11, 32'h22);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'h0, 32'h8000_0000);
        run_op("div_neg", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 10, 32'h1, 32'hFFFF_FFFD);
        run_op("divu", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'h1, 32'h7FFF_FFFC);

        // MTHI and a second MULT while BUSY must both be ignored
        e_op   = OP_MULT;
        e_num1 = 32'd2;
        e_num2 = 32'd3;
        tick();
        e_op   = OP_MTHI;
        e_num1 = 32'hDEAD;
        #1;
        chk("busy_mthi_busy", 32'(busy), 32'd1);
        tick();
        e_op   = OP_MULT;
        e_num1 = 32'd100;
        #1;
        chk("busy_no_start", 32'(start), 32'd0);
        e_op = OP_MD_NONE;
        for (int i = 0; i < 4; i++) tick();
        chk("busy_ign_busy", 32'(busy), 32'd0);
        chk("busy_ign_hi", hi, 32'd0);
        chk("busy_ign_lo", lo, 32'd6);

        // Async reset in the third BUSY cycle of a DIV discards the pending result
        e_op   = OP_DIV;
        e_num1 = 32'd100;
        e_num2 = 32'd7;
        tick();
        e_op = OP_MD_NONE;
        tick();
        tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        run_op("mult_after_rst", OP_MULT, 32'd7, 32'hFFFF_FFF7, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFC1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
